// File: rtl/freqdiv_prog.sv
// Runtime-programmable clock divider: square or one-cycle pulse output, a tick strobe,
// and divisor changes that only take effect at period boundaries (wrap, clr, or while idle).
module freqdiv_prog #(
    parameter int CNT_W       = 27,
    parameter int DIV_DEFAULT = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] d, d_nxt;
    logic [CNT_W-1:0] p, p_nxt;
    logic             pv, pv_nxt;
    logic             clk_upd, clk_nxt;
    logic             wrap, load_ok, load_bad;
    logic [CNT_W-1:0] d_sel;

    assign wrap     = en & (cnt == d - ONE);
    assign load_ok  = div_load & (div_val != '0);
    assign load_bad = div_load & (div_val == '0);
    // A same-cycle load wins over an older pending value at any boundary.
    assign d_sel    = load_ok ? div_val : (pv ? p : d);

    always_comb begin
        cnt_nxt = cnt;
        d_nxt   = d;
        p_nxt   = p;
        pv_nxt  = pv;
        clk_upd = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
            d_nxt   = d_sel;
            pv_nxt  = 1'b0;
            clk_upd = 1'b1;
        end else if (!en) begin
            if (load_ok) begin
                cnt_nxt = '0;
                d_nxt   = div_val;
                pv_nxt  = 1'b0;
                clk_upd = 1'b1;
            end
        end else if (wrap) begin
            cnt_nxt = '0;
            d_nxt   = d_sel;
            pv_nxt  = 1'b0;
            clk_upd = 1'b1;
        end else begin
            cnt_nxt = cnt + ONE;
            clk_upd = 1'b1;
            if (load_ok) begin
                p_nxt  = div_val;
                pv_nxt = 1'b1;
            end
        end
    end

    // With cnt_nxt==0 the square branch reduces to (floor(D'/2)==0), i.e. D'==1.
    assign clk_nxt = mode ? (cnt_nxt == '0) : (cnt_nxt >= (d_nxt >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            d        <= DIV_INIT;
            p        <= '0;
            pv       <= 1'b0;
            clk_out  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            d        <= d_nxt;
            p        <= p_nxt;
            pv       <= pv_nxt;
            load_err <= load_bad;
            if (clk_upd) begin
                clk_out <= clk_nxt;
            end
        end
    end

    assign tick    = wrap;
    assign div_cur = d;

endmodule
